// File: rtl/vga_timing_generator.sv
// -----------------------------------------------------------------------------
// vga_timing_generator
//
// Parametrised raster timing generator for the video output path. A line is
// laid out as sync, back porch, active, front porch with h=0 the first sync
// pixel; frames are laid out the same way in lines.
//
// Every output is a flop loaded from the decode of the *next* position. Each
// output therefore always matches the decode of the position currently held
// in the counters, with no lag and no combinational path from the counters.
//
// Ports:
//   clock        pixel clock
//   resetN       asynchronous active-low reset
//   clockEnable  the position advances one pixel only on cycles where this is 1
//   hSync/vSync  sync outputs, asserted level set by H_SYNC_POL / V_SYNC_POL
//   isActive     current position is a visible pixel
//   x, y         active coordinates, 0 outside the active area
//   isFetch      current position is LEAD enabled steps before a visible pixel
//   fetchX/Y     coordinates displayed LEAD steps later, 0 when not fetching
//   lineStart    one-clock pulse after an enabled move from H_TOTAL-1 to h=0
//   frameStart   one-clock pulse after an enabled move into (0,0)
//   frameCount   completed-frame counter, wraps
//
// There is no valid/ready handshake: clockEnable alone qualifies every
// advance, and with clockEnable low all level outputs hold while both
// pulses drop to 0.
// -----------------------------------------------------------------------------
module vga_timing_generator #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FPORCH    = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BPORCH    = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FPORCH    = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BPORCH    = 33,
    parameter bit H_SYNC_POL  = 1'b0,
    parameter bit V_SYNC_POL  = 1'b0,
    parameter int LEAD        = 2,
    parameter int X_WIDTH     = 10,
    parameter int Y_WIDTH     = 9,
    parameter int FRAME_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   clockEnable,
    output logic                   hSync,
    output logic                   vSync,
    output logic                   isActive,
    output logic [X_WIDTH-1:0]     x,
    output logic [Y_WIDTH-1:0]     y,
    output logic                   isFetch,
    output logic [X_WIDTH-1:0]     fetchX,
    output logic [Y_WIDTH-1:0]     fetchY,
    output logic                   lineStart,
    output logic                   frameStart,
    output logic [FRAME_WIDTH-1:0] frameCount
);

    localparam int H_TOTAL  = H_SYNC + H_BPORCH + H_ACTIVE + H_FPORCH;
    localparam int HA_START = H_SYNC + H_BPORCH;
    localparam int HA_END   = HA_START + H_ACTIVE;
    localparam int HF_START = HA_START - LEAD;
    localparam int HF_END   = HA_END - LEAD;
    localparam int V_TOTAL  = V_SYNC + V_BPORCH + V_ACTIVE + V_FPORCH;
    localparam int VA_START = V_SYNC + V_BPORCH;
    localparam int VA_END   = VA_START + V_ACTIVE;

    // One spare code so the exclusive end bounds fit even with empty porches.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // Reject geometries the outputs cannot represent.
    if (LEAD < 1 || LEAD > H_SYNC + H_BPORCH) begin : g_bad_lead
        $error("vga_timing_generator: LEAD must be within 1..H_SYNC+H_BPORCH");
    end
    if (H_ACTIVE > (1 << X_WIDTH)) begin : g_bad_x_width
        $error("vga_timing_generator: X_WIDTH cannot hold H_ACTIVE-1");
    end
    if (V_ACTIVE > (1 << Y_WIDTH)) begin : g_bad_y_width
        $error("vga_timing_generator: Y_WIDTH cannot hold V_ACTIVE-1");
    end

    logic [HW-1:0] h;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v;
    logic [VW-1:0] v_next;
    logic          line_wrap;
    logic          frame_wrap;
    logic          h_act;
    logic          v_act;
    logic          h_fetch;
    logic [HW-1:0] x_off;
    logic [HW-1:0] fx_off;
    logic [VW-1:0] y_off;

    // Next position and decode of that position.
    always_comb begin
        line_wrap  = clockEnable && (h == H_LAST);
        frame_wrap = line_wrap && (v == V_LAST);
        h_next     = h;
        v_next     = v;
        if (clockEnable) begin
            if (line_wrap) begin
                h_next = '0;
                v_next = frame_wrap ? '0 : v + 1'b1;
            end else begin
                h_next = h + 1'b1;
            end
        end

        h_act   = (h_next >= HW'(HA_START)) && (h_next < HW'(HA_END));
        v_act   = (v_next >= VW'(VA_START)) && (v_next < VW'(VA_END));
        h_fetch = (h_next >= HW'(HF_START)) && (h_next < HW'(HF_END));
        x_off   = h_next - HW'(HA_START);
        fx_off  = h_next - HW'(HF_START);
        y_off   = v_next - VW'(VA_START);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            h          <= '0;
            v          <= '0;
            hSync      <= H_SYNC_POL;
            vSync      <= V_SYNC_POL;
            isActive   <= 1'b0;
            x          <= '0;
            y          <= '0;
            isFetch    <= 1'b0;
            fetchX     <= '0;
            fetchY     <= '0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
            frameCount <= '0;
        end else begin
            h          <= h_next;
            v          <= v_next;
            hSync      <= (h_next < HW'(H_SYNC)) ? H_SYNC_POL : ~H_SYNC_POL;
            vSync      <= (v_next < VW'(V_SYNC)) ? V_SYNC_POL : ~V_SYNC_POL;
            isActive   <= h_act && v_act;
            x          <= (h_act && v_act) ? X_WIDTH'(x_off) : '0;
            y          <= (h_act && v_act) ? Y_WIDTH'(y_off) : '0;
            isFetch    <= h_fetch && v_act;
            fetchX     <= (h_fetch && v_act) ? X_WIDTH'(fx_off) : '0;
            fetchY     <= (h_fetch && v_act) ? Y_WIDTH'(y_off) : '0;
            // Pulses are cleared on every cycle that does not wrap, including
            // cycles with clockEnable low.
            lineStart  <= line_wrap;
            frameStart <= frame_wrap;
            if (frame_wrap) begin
                frameCount <= frameCount + 1'b1;
            end
        end
    end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Parametrised raster timing generator for the video output path; successor to the fixed 640x480 sync counter.
- Generates horizontal and vertical sync with programmable polarity, an active-video flag, and pixel coordinates. Coordinates are clamped to 0 outside the active area.
- Adds per-pixel clock-enable gating, line-start and frame-start pulses, a frame counter, and a lookahead fetch window so the framebuffer or sprite pipeline can issue reads LEAD pixels early.
- Sits between the pixel clock domain and the pixel source / DAC drivers.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FPORCH, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BPORCH, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FPORCH, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BPORCH, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hSync level while asserted (0 = active-low)
- V_SYNC_POL, 0, vSync level while asserted
- LEAD, 2, fetch lookahead in enabled pixel steps; 1 <= LEAD <= H_SYNC+H_BPORCH
- X_WIDTH, 10, width of x/fetchX; must hold H_ACTIVE-1
- Y_WIDTH, 9, width of y/fetchY; must hold V_ACTIVE-1
- FRAME_WIDTH, 16, frame counter width

Ports:
- clock  input  1  pixel clock
- resetN  input  1  reset, asynchronous, active-low
- clockEnable  input  1  position advances only on cycles where this is 1
- hSync  output  1  horizontal sync, polarity per H_SYNC_POL
- vSync  output  1  vertical sync, polarity per V_SYNC_POL
- isActive  output  1  current position is a visible pixel
- x  output  X_WIDTH  active pixel column, 0 when not active
- y  output  Y_WIDTH  active line, 0 when not active
- isFetch  output  1  current position is LEAD steps before a visible pixel
- fetchX  output  X_WIDTH  column to be displayed LEAD steps later, 0 when not fetching
- fetchY  output  Y_WIDTH  line of that column, 0 when not fetching
- lineStart  output  1  one-clock pulse on entering h=0
- frameStart  output  1  one-clock pulse on entering (0,0)
- frameCount  output  FRAME_WIDTH  completed-frame counter, wraps

Behaviour:
- Derived constants:
  - H_TOTAL = H_SYNC+H_BPORCH+H_ACTIVE+H_FPORCH; HA_START = H_SYNC+H_BPORCH; HA_END = HA_START+H_ACTIVE.
  - V_TOTAL, VA_START and VA_END are formed likewise. Defaults give H_TOTAL 800, V_TOTAL 525, HA_START 144, VA_START 35.
- Position (h,v):
  - Internal counters sized from the totals. Line order is sync, back porch, active, front porch, with h=0 the first sync pixel.
  - On a clock edge with clockEnable=1, h increments. At h=H_TOTAL-1, h wraps to 0 and v increments; v wraps from V_TOTAL-1 to 0.
  - With clockEnable=0, position and all level outputs hold.
- Outputs:
  - All outputs are registered flops, computed from the next position, so each output always equals the decode of the current position with zero lag and no combinational path from counters.
- Decode:
  - hSync = H_SYNC_POL when h < H_SYNC, else inverse. vSync is the same with v and V_SYNC.
  - isActive = HA_START <= h < HA_END and VA_START <= v < VA_END.
  - x = h-HA_START and y = v-VA_START when isActive, else both 0.
  - isFetch = HA_START-LEAD <= h < HA_END-LEAD and v in the active range.
  - fetchX = h-(HA_START-LEAD) and fetchY = v-VA_START when isFetch, else both 0.
- Pulses:
  - lineStart=1 for exactly one clock after an enabled edge moves h from H_TOTAL-1 to 0.
  - frameStart=1 for one clock after the enabled move into (0,0); lineStart is also 1 in that clock.
  - On any cycle without such a move, both pulses are 0, including when clockEnable is held 0.
- frameCount increments in the same edge that raises frameStart; wraps from all-ones to 0.
- Reset (resetN low, asynchronous, any time including mid-frame):
  - Position (0,0), frameCount 0.
  - hSync=H_SYNC_POL, vSync=V_SYNC_POL, isActive 0, x 0, y 0, isFetch 0, fetchX 0, fetchY 0, lineStart 0, frameStart 0.
  - First enabled edge after release moves to (1,0); no pulse is generated for the reset position.
- Elaboration must fail (generate-time error) if LEAD is out of range or X_WIDTH/Y_WIDTH are too small.

Test Plan:
- Defaults, clockEnable=1 after reset → hSync=0 for h 0..95, 1 at h=96; vSync=0 for v 0..1; lineStart every 800 clocks; frameStart every 420000 clocks; frameCount=1 after the first wrap.
- Defaults, probe active edges → at (143,35) isActive=0, x=0; at (144,35) isActive=1, x=0, y=0; at (783,514) x=639, y=479; at (784,514) isActive=0, x=0, y=0.
- Defaults, LEAD=2 → isFetch first 1 at (142,35) with fetchX=0; last at h=781 with fetchX=639; 0 at h=782 and on v=34.
- clockEnable toggling 1,0,1,0 → line period 1600 clocks; lineStart/frameStart remain single-clock; outputs hold on disabled cycles.
- Assert resetN at (400,200) for 3 clocks, asynchronously mid-cycle → outputs take reset values without a clock edge; after release the frame restarts from (0,0); frameCount=0.
- Params H_ACTIVE=4, H_FPORCH=1, H_SYNC=2, H_BPORCH=1, V_ACTIVE=2, V_FPORCH=1, V_SYNC=1, V_BPORCH=1, both POL=1, LEAD=1 → H_TOTAL=8, V_TOTAL=5; hSync=1 at h 0..1; isActive at h 3..6, v 2..3; isFetch at h 2..5; frameStart every 40 clocks.
